// File: rtl/led_pkg.sv
// led_pkg: shared channel count, PWM width and fade-state encoding for the LED fader.
package led_pkg;
    localparam int LED_CH = 4;
    localparam int PWM_W  = 8;
    typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} ch_state_t;
endpackage

// File: rtl/led_fade_ch.sv
// led_fade_ch: one LED channel -- fade FSM, brightness level, duty map and PWM output bit.
// Define LED_PWM_GAMMA_EN for a square-law duty curve; the default build is linear.
module led_fade_ch
    import led_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             step_tick,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led_out,
    output logic             busy
);
    localparam logic [PWM_W-1:0] FULL = '1;

    ch_state_t        state, state_nxt;
    logic [PWM_W-1:0] level, target, duty, duty_q;

    assign target = req ? FULL : '0;

`ifdef LED_PWM_GAMMA_EN
    assign duty = &level ? FULL : PWM_W'(((2*PWM_W)'(level) * (2*PWM_W)'(level)) >> PWM_W);
`else
    assign duty = level;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= OFF;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OFF:       state_nxt = req ? RAMP_UP : OFF;
            RAMP_UP:   state_nxt = !req ? RAMP_DOWN : &level ? ON : RAMP_UP;
            ON:        state_nxt = req ? ON : RAMP_DOWN;
            RAMP_DOWN: state_nxt = req ? RAMP_UP : level == '0 ? OFF : RAMP_DOWN;
            default:   state_nxt = OFF;
        endcase
    end

    always_comb busy = state == RAMP_UP || state == RAMP_DOWN;

    // Duty is only updated at the period boundary so a running period never glitches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level   <= '0;
            duty_q  <= '0;
            led_out <= 1'b0;
        end else begin
            if (step_tick && level != target)
                level <= level < target ? level + 1'b1 : level - 1'b1;
            if (&pwm_cnt)
                duty_q <= duty;
            led_out <= &duty_q || pwm_cnt < duty_q;
        end
    end
endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: LED_CH-channel LED fader sharing one PWM counter and one brightness-step timebase.
// Build with LED_PWM_GAMMA_EN defined for square-law brightness; linear otherwise.
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int unsigned STEP_DIV = 48_828
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LED_CH-1:0] led_in,
    output logic [LED_CH-1:0] led_out,
    output logic [LED_CH-1:0] busy
);
    logic [LED_CH-1:0] led_in_q;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [31:0]       step_cnt;
    logic              step_tick;

    assign step_tick = step_cnt == 32'(STEP_DIV - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_in_q <= '0;
            pwm_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            led_in_q <= led_in;
            pwm_cnt  <= pwm_cnt + 1'b1;
            step_cnt <= step_tick ? '0 : step_cnt + 32'd1;
        end
    end

    for (genvar i = 0; i < LED_CH; i++) begin : g_ch
        led_fade_ch u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .req      (led_in_q[i]),
            .step_tick(step_tick),
            .pwm_cnt  (pwm_cnt),
            .led_out  (led_out[i]),
            .busy     (busy[i])
        );
    end
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: scoreboard bench for led_pwm_fader with STEP_DIV=4 (dut) and STEP_DIV=1 (dut1).
`timescale 1ns/1ps
module tb_led_pwm_fader;
    import led_pkg::*;

    typedef struct { string name; int sel; logic [31:0] exp; } chk_t;
    typedef struct { string name; int exp; } per_t;

    localparam int S_LED = 0, S_BUSY = 1, S_LVLS = 2, S_LVL0 = 3, S_LVL1 = 4, S_ST1 = 5,
                   S_BUSY0 = 6, S_BUSY1 = 7, S_BLVL = 8, S_BST = 9, S_BBUSY = 10, S_BLED = 11;

    logic       clk = 1'b0;
    logic       rst_n, rst1_n;
    logic [3:0] led_in, led_in1, led_out, led_out1, busy, busy1;

    chk_t chk_q[$];
    per_t per_q[$];
    chk_t c;
    per_t p;
    int   errors = 0, checks = 0, acc = 0;

    always #5 clk = ~clk;

    led_pwm_fader #(.STEP_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .led_in(led_in), .led_out(led_out), .busy(busy)
    );
    led_pwm_fader #(.STEP_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .led_in(led_in1), .led_out(led_out1), .busy(busy1)
    );

    function automatic logic [31:0] act(int sel);
        case (sel)
            S_LED:   return 32'(led_out);
            S_BUSY:  return 32'(busy);
            S_LVLS:  return {dut.g_ch[3].u_ch.level, dut.g_ch[2].u_ch.level,
                             dut.g_ch[1].u_ch.level, dut.g_ch[0].u_ch.level};
            S_LVL0:  return 32'(dut.g_ch[0].u_ch.level);
            S_LVL1:  return 32'(dut.g_ch[1].u_ch.level);
            S_ST1:   return 32'(dut.g_ch[1].u_ch.state);
            S_BUSY0: return 32'(busy[0]);
            S_BUSY1: return 32'(busy[1]);
            S_BLVL:  return 32'(dut1.g_ch[0].u_ch.level);
            S_BST:   return 32'(dut1.g_ch[0].u_ch.state);
            S_BBUSY: return 32'(busy1[0]);
            S_BLED:  return 32'(led_out1);
            default: return '1;
        endcase
    endfunction

    // Expected high cycles per PWM period for a given level.
    function automatic int hc(int l);
        int d;
`ifdef LED_PWM_GAMMA_EN
        d = (l == 255) ? 255 : (l * l) >> 8;
`else
        d = l;
`endif
        return (d == 255) ? 256 : d;
    endfunction

    always @(negedge clk) begin
        #1;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            checks++;
            if (act(c.sel) !== c.exp) begin
                errors++;
                $display("FAIL %s: got %0h, want %0h", c.name, act(c.sel), c.exp);
            end
        end
        if (!rst_n) acc = 0;
        else begin
            acc += int'(led_out[0]);
            if (dut.pwm_cnt == 8'h00) begin
                if (per_q.size() > 0) begin
                    p = per_q.pop_front();
                    checks++;
                    if (acc != p.exp) begin
                        errors++;
                        $display("FAIL %s: got %0d high cycles, want %0d", p.name, acc, p.exp);
                    end
                end
                acc = 0;
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(string n, int sel, logic [31:0] e);
        chk_t t;
        t.name = n; t.sel = sel; t.exp = e;
        chk_q.push_back(t);
    endtask

    task automatic per(string n, int e);
        per_t t;
        t.name = n; t.exp = e;
        per_q.push_back(t);
    endtask

    task automatic wait_pwm(logic [7:0] v);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (dut.pwm_cnt != v && k < 300);
    endtask

    task automatic wait_step0();
        int k = 0;
        while (dut.step_cnt != 0 && k < 8) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int k;
        rst_n = 1'b0; led_in = 4'hF; rst1_n = 1'b0; led_in1 = 4'h0;
        cyc(3);
        chk("rst_led_out", S_LED, 0);
        chk("rst_busy", S_BUSY, 0);
        chk("rst_levels", S_LVLS, 0);
        chk("rst_dut1_led_out", S_BLED, 0);
        rst_n = 1'b1; led_in = 4'h0;
        cyc(3);
        chk("idle_busy", S_BUSY, 0);

        // Fade-up of channel 0, aligned to a fresh step period.
        wait_step0();
        led_in = 4'h1;
        k = 0;
        while (!busy[0] && k < 6) begin
            @(negedge clk);
            k++;
        end
        chk("busy0_rise", S_BUSY0, 1);
        cyc(1019 - k);
        chk("fade_lvl_fe", S_LVL0, 8'hFE);
        cyc(1);
        chk("fade_lvl_ff", S_LVL0, 8'hFF);
        k = 0;
        while (busy[0] && k < 4) begin
            @(negedge clk);
            k++;
        end
        chk("busy0_fall", S_BUSY0, 0);
        wait_pwm(1);
        wait_pwm(1);
        per("on_full_a", 256);
        per("on_full_b", 256);
        wait_pwm(1);
        wait_pwm(1);

        // Reversal of channel 1 at level 0x40.
        wait_step0();
        led_in = 4'h3;
        cyc(256);
        chk("rev_lvl_40", S_LVL1, 8'h40);
        chk("rev_st_up", S_ST1, RAMP_UP);
        led_in = 4'h1;
        cyc(3);
        chk("rev_lvl_hold", S_LVL1, 8'h40);
        cyc(1);
        chk("rev_lvl_3f", S_LVL1, 8'h3F);
        chk("rev_st_down", S_ST1, RAMP_DOWN);
        cyc(252);
        chk("rev_lvl_00", S_LVL1, 8'h00);
        k = 0;
        while (busy[1] && k < 4) begin
            @(negedge clk);
            k++;
        end
        chk("rev_busy1_fall", S_BUSY1, 0);
        chk("rev_st_off", S_ST1, OFF);

        // Duty timing: each forced level shows up in the period after it is applied.
        rst_n = 1'b0; led_in = 4'h0;
        cyc(2);
        rst_n = 1'b1;
        wait_pwm(1);
        per("duty_zero", 0);
        wait_pwm(100);
        force dut.g_ch[0].u_ch.level = 8'h80;
        wait_pwm(1);
        per("duty_80", hc(8'h80));
        wait_pwm(100);
        force dut.g_ch[0].u_ch.level = 8'hFF;
        wait_pwm(1);
        per("duty_ff", hc(8'hFF));
        wait_pwm(100);
        force dut.g_ch[0].u_ch.level = 8'h0F;
        wait_pwm(1);
        per("duty_0f", hc(8'h0F));
        wait_pwm(100);
        force dut.g_ch[0].u_ch.level = 8'h20;
        wait_pwm(1);
        per("duty_20", hc(8'h20));
        wait_pwm(1);
        release dut.g_ch[0].u_ch.level;

        // STEP_DIV=1: one level step per cycle, then reset mid-ramp at 0x90.
        rst1_n = 1'b1; led_in1 = 4'h1;
        cyc(2);
        chk("div1_lvl_01", S_BLVL, 8'h01);
        cyc(1);
        chk("div1_lvl_02", S_BLVL, 8'h02);
        cyc(142);
        chk("div1_lvl_90", S_BLVL, 8'h90);
        chk("div1_busy_ramp", S_BBUSY, 1);
        rst1_n = 1'b0;
        cyc(1);
        chk("div1_rst_lvl", S_BLVL, 8'h00);
        chk("div1_rst_st", S_BST, OFF);
        chk("div1_rst_busy", S_BBUSY, 0);
        rst1_n = 1'b1;
        cyc(2);
        chk("div1_restart", S_BLVL, 8'h01);

        cyc(2);
        if (per_q.size() != 0) begin
            errors += per_q.size();
            $display("FAIL period_queue: got %0d unchecked periods, want 0", per_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
